sm_dbg_ctrl: RTL

SM_DBG_CTRL -- requirements
Module: sm_dbg_ctrl

---
 rtl/sm_dbg_pkg.sv | 14 +
 rtl/sm_dbg_ctrl_if.sv | 26 ++
 rtl/sm_debounce.sv | 55 +++++
 rtl/sm_dbg_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sm_dbg_pkg.sv
// rtl/sm_dbg_pkg.sv - shared state encodings, divider default and byte-select helper
package sm_dbg_pkg;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [3:0] DIV_DEFAULT = 4'b1010;

    function automatic logic [7:0] sel_byte(input logic [31:0] data, input logic [1:0] sel);
        return data[8*sel +: 8];
    endfunction

endpackage

// File: rtl/sm_dbg_ctrl_if.sv
// rtl/sm_dbg_ctrl_if.sv - debug port bundle between the controller and the core
interface sm_dbg_ctrl_if;

    logic        clkEnable;
    logic [3:0]  clkDevide;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        clk_core;

    modport master (
        output clkEnable,
        output clkDevide,
        output regAddr,
        input  regData,
        input  clk_core
    );

    modport slave (
        input  clkEnable,
        input  clkDevide,
        input  regAddr,
        output regData,
        output clk_core
    );

endinterface

// File: rtl/sm_debounce.sv
// rtl/sm_debounce.sv - 2-flop synchronizer followed by a consecutive-sample debouncer
module sm_debounce #(
    parameter int CYCLES         = 500000,
    parameter bit ARM_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_armed;
    logic          w_sample;
    logic          w_done;

    assign w_sample = r_sync[1];
    assign w_done   = (r_cnt == CW'(CYCLES - 1));
    assign o_level  = r_level;

    // When arming is enabled, the input must first be seen low for a full
    // debounce period, so a level already asserted during reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_armed <= ~ARM_ON_RELEASE;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (!r_armed) begin
                if (w_sample) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_armed <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= w_sample;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_dbg_ctrl.sv
// rtl/sm_dbg_ctrl.sv - run/halt/step control, divider lock, register scan and byte display
module sm_dbg_ctrl
    import sm_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic        sw_run,
    input  logic        btn_step,
    input  logic        sw_scan,
    input  logic [4:0]  sw_addr,
    input  logic [3:0]  sw_div,
    input  logic [1:0]  sw_byte,
    input  logic        clk_core,
    input  logic [31:0] regData,
    output logic        clkEnable,
    output logic [3:0]  clkDevide,
    output logic [4:0]  regAddr,
    output logic [7:0]  dispData,
    output logic [1:0]  state_led
);

    localparam int TW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic          w_run;
    logic          w_btn;
    logic          w_scan;
    logic          w_step_req;
    logic          w_core_rise;
    logic [1:0]    w_next;

    logic [1:0]    r_state;
    logic          r_btn_prev;
    logic [1:0]    r_core_sync;
    logic          r_core_prev;
    logic          r_scan_prev;
    logic [TW-1:0] r_timer;
    logic          r_clk_en;
    logic [3:0]    r_div;
    logic [4:0]    r_addr;
    logic [7:0]    r_disp;

    sm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ARM_ON_RELEASE(1'b0)) u_db_run (
        .clk     (clkIn),
        .rst     (rst),
        .i_raw   (sw_run),
        .o_level (w_run)
    );

    sm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ARM_ON_RELEASE(1'b1)) u_db_step (
        .clk     (clkIn),
        .rst     (rst),
        .i_raw   (btn_step),
        .o_level (w_btn)
    );

    sm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ARM_ON_RELEASE(1'b0)) u_db_scan (
        .clk     (clkIn),
        .rst     (rst),
        .i_raw   (sw_scan),
        .o_level (w_scan)
    );

    assign w_step_req  = w_btn & ~r_btn_prev;
    assign w_core_rise = r_core_sync[1] & ~r_core_prev;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (w_run)
                    w_next = ST_RUN;
                else if (w_step_req)
                    w_next = ST_STEP;
            end
            ST_RUN: begin
                if (!w_run)
                    w_next = ST_HALT;
            end
            ST_STEP: begin
                if (w_run)
                    w_next = ST_RUN;
                else if (w_core_rise)
                    w_next = ST_HALT;
            end
            default: w_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            r_state     <= ST_HALT;
            r_btn_prev  <= 1'b0;
            r_core_sync <= 2'b00;
            r_core_prev <= 1'b0;
            r_clk_en    <= 1'b0;
            r_div       <= DIV_DEFAULT;
        end else begin
            r_state     <= w_next;
            r_btn_prev  <= w_btn;
            r_core_sync <= {r_core_sync[0], clk_core};
            r_core_prev <= r_core_sync[1];
            r_clk_en    <= (r_state != ST_HALT);
            if (r_state == ST_HALT)
                r_div <= sw_div;
        end
    end

    // A rising scan level restarts the dwell timer without moving the address.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            r_scan_prev <= 1'b0;
            r_timer     <= '0;
            r_addr      <= 5'd0;
        end else begin
            r_scan_prev <= w_scan;
            if (!w_scan) begin
                r_timer <= '0;
                r_addr  <= sw_addr;
            end else if (!r_scan_prev) begin
                r_timer <= '0;
            end else if (r_timer == TW'(SCAN_CYCLES - 1)) begin
                r_timer <= '0;
                r_addr  <= r_addr + 5'd1;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rst)
            r_disp <= 8'h00;
        else
            r_disp <= sel_byte(regData, sw_byte);
    end

    assign clkEnable = r_clk_en;
    assign clkDevide = r_div;
    assign regAddr   = r_addr;
    assign dispData  = r_disp;
    assign state_led = r_state;

endmodule
